// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    SUB  = 4'b0001,
    AND  = 4'b0010,
    ORR  = 4'b0011,
    EOR  = 4'b0100,
    MOV  = 4'b0101,
    CMP  = 4'b0110,
    MUL  = 4'b0111,
    LDR  = 4'b1000,
    STR  = 4'b1001,
    UDIV = 4'b1010
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {IDLE, ITER} state_e;

  // Ops that go through the iterative datapath.
  function automatic logic is_multi(input logic [3:0] op);
    return (op == MUL) || (op == UDIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Issue/result bundle between the control unit and the ALU.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (output start, op, a, b,
                  input  result, flags, busy, done, illegal);
  modport slave  (input  start, op, a, b,
                  output result, flags, busy, done, illegal);
endinterface

// File: rtl/alu_iter.sv
// Shared shift-add multiplier / restoring divider. acc and quo are the
// values *after* the current step, so the final step's outcome can be
// written to the result register on the same edge that performs it.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] quo,
  output logic             div0
);
  // mul: x = multiplicand (shifts left), y = multiplier (shifts right), r = product
  // div: x = divisor, y = dividend becoming quotient, r = partial remainder
  logic [WIDTH-1:0] x, y, r;
  logic [WIDTH-1:0] x_nxt, y_nxt, r_nxt, rem_diff;
  logic [WIDTH:0]   rem_sh;
  logic             ge;

  // One iteration of whichever algorithm is selected.
  always_comb begin
    rem_sh   = {r, y[WIDTH-1]};
    ge       = rem_sh >= {1'b0, x};
    rem_diff = rem_sh[WIDTH-1:0] - x;
    if (is_div) begin
      x_nxt = x;
      y_nxt = {y[WIDTH-2:0], ge};
      r_nxt = ge ? rem_diff : rem_sh[WIDTH-1:0];
    end else begin
      x_nxt = x << 1;
      y_nxt = y >> 1;
      r_nxt = r + (y[0] ? x : '0);
    end
  end

  assign acc = r_nxt;
  assign quo = y_nxt;

  // Operand load on issue, then one iteration per step.
  always_ff @(posedge clk) begin
    if (load) begin
      x    <= is_div ? b : a;
      y    <= is_div ? a : b;
      r    <= '0;
      div0 <= (b == '0);
    end else if (step) begin
      x <= x_nxt;
      y <= y_nxt;
      r <= r_nxt;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops finish on the issue edge, MUL/UDIV
// run WIDTH iterations in alu_iter while busy is held.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int            MSB  = WIDTH - 1;

  state_e           state;
  logic [CW-1:0]    count;
  logic             is_div_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             busy_q, done_q, illegal_q;

  logic             load, step, it_div, div0;
  logic [WIDTH-1:0] acc, quo;

  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] lg;
  logic [WIDTH-1:0] sc_result;
  logic [3:0]       sc_flags;
  logic             sc_illegal;

  assign load   = (state == IDLE) && bus.start && is_multi(bus.op);
  assign step   = (state == ITER);
  assign it_div = load ? (bus.op == UDIV) : is_div_q;

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .load   (load),
    .step   (step),
    .is_div (it_div),
    .a      (bus.a),
    .b      (bus.b),
    .acc    (acc),
    .quo    (quo),
    .div0   (div0)
  );

  // Single-cycle datapath; defaults leave result/flags untouched.
  always_comb begin
    sum        = {1'b0, bus.a} + {1'b0, bus.b};
    dif        = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    lg         = '0;
    sc_result  = result_q;
    sc_flags   = flags_q;
    sc_illegal = 1'b0;
    case (bus.op)
      ADD, LDR: begin
        sc_result        = sum[MSB:0];
        sc_flags[FLAG_N] = sum[MSB];
        sc_flags[FLAG_Z] = (sum[MSB:0] == '0);
        sc_flags[FLAG_C] = sum[WIDTH];
        sc_flags[FLAG_V] = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      SUB, CMP: begin
        if (bus.op == SUB) sc_result = dif[MSB:0];
        sc_flags[FLAG_N] = dif[MSB];
        sc_flags[FLAG_Z] = (dif[MSB:0] == '0);
        sc_flags[FLAG_C] = dif[WIDTH];
        sc_flags[FLAG_V] = (bus.a[MSB] != bus.b[MSB]) && (dif[MSB] != bus.a[MSB]);
      end
      STR: sc_result = sum[MSB:0];
      AND, ORR, EOR, MOV: begin
        case (bus.op)
          AND:     lg = bus.a & bus.b;
          ORR:     lg = bus.a | bus.b;
          EOR:     lg = bus.a ^ bus.b;
          default: lg = bus.b;
        endcase
        sc_result        = lg;
        sc_flags[FLAG_N] = lg[MSB];
        sc_flags[FLAG_Z] = (lg == '0);
      end
      MUL, UDIV: ;
      default: sc_illegal = 1'b1;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      is_div_q  <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (is_multi(bus.op)) begin
              state    <= ITER;
              busy_q   <= 1'b1;
              count    <= '0;
              is_div_q <= (bus.op == UDIV);
            end else begin
              result_q  <= sc_result;
              flags_q   <= sc_flags;
              done_q    <= 1'b1;
              illegal_q <= sc_illegal;
            end
          end
        end
        ITER: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            count  <= '0;
            if (is_div_q) begin
              result_q         <= quo;
              flags_q[FLAG_N]  <= quo[MSB];
              flags_q[FLAG_Z]  <= (quo == '0);
              flags_q[FLAG_V]  <= div0;
            end else begin
              result_q         <= acc;
              flags_q[FLAG_N]  <= acc[MSB];
              flags_q[FLAG_Z]  <= (acc == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result  = result_q;
  assign bus.flags   = flags_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
endmodule
